iram_fetch_arbiter: RTL and testbench

- Shares the single-port, registered-read instruction RAM between NUM_CORES core fetch units using round-robin arbitration. Each core gets at most one fetch in flight.
- Sequences a program run: start, run until every enabled core has reported ENDOP, then done.
- Sits between the cores' PC/fetch logic and the IRAM. It drives the IRAM address and routes the returned instruction word to the owning core.

---
 rtl/iram_pkg.sv | 23 ++
 rtl/iram_fetch_arbiter_rr_picker.sv | 36 +++
 rtl/iram_fetch_arbiter.sv | 147 ++++++++++++++
 tb/tb_iram_fetch_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared types and constants for the IRAM fetch arbiter and its cores.
// Holds FSM encoding, bus width defaults and the core-side opcodes.
package iram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Instruction words the cores decode; ENDOP halts a core.
  localparam logic [15:0] OP_NOP   = 16'd0;
  localparam logic [15:0] OP_LOAD  = 16'd3;
  localparam logic [15:0] OP_STORE = 16'd35;
  localparam logic [15:0] OP_ALU   = 16'd19;
  localparam logic [15:0] OP_BR    = 16'd99;
  localparam logic [15:0] OP_JMP   = 16'd111;
  localparam logic [15:0] ENDOP    = 16'd51;

endpackage

// File: rtl/iram_fetch_arbiter_rr_picker.sv
// Round-robin first-one search: lowest set bit at or above ptr,
// wrapping modulo N.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] winner
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  always_comb begin
    dbl    = {eligible, eligible};
    rot    = N'(dbl >> ptr);
    found  = 1'b0;
    off    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N) begin
      sum = sum - N;
    end
    winner = ID_W'(sum);
  end

endmodule

// File: rtl/iram_fetch_arbiter.sv
// Shares a registered-read IRAM among NUM_CORES fetch units and
// sequences a run from start until every enabled core has halted.
module iram_fetch_arbiter
  import iram_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_en,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES-1:0]        core_halt,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           iram_addr,
  input  logic [DATA_W-1:0]           iram_rdata,
  output logic                        running,
  output logic                        all_done
);

  localparam int ID_W = $clog2(NUM_CORES);

  state_t state;
  state_t state_nx;

  logic [NUM_CORES-1:0] en_q;
  logic [NUM_CORES-1:0] halted;
  logic [NUM_CORES-1:0] eligible;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      s1_id;
  logic [ID_W-1:0]      s2_id;
  logic [ID_W-1:0]      win;
  logic                 s1_valid;
  logic                 s2_valid;
  logic                 found;
  logic                 run;
  logic                 load;
  logic                 finished;

  logic [ADDR_W-1:0] addr_arr [NUM_CORES];

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      addr_arr[i] = core_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign run      = (state == RUN);
  assign finished = (&(halted | ~en_q)) & ~s1_valid & ~s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (core_en == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (finished) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A halt on the same edge as a request beats it; a visible grant
  // masks the core's not-yet-dropped request.
  always_comb begin
    eligible = '0;
    if (run) begin
      eligible = core_req & en_q & ~halted & ~core_gnt & ~core_halt;
    end
  end

  rr_picker #(
    .N    (NUM_CORES),
    .ID_W (ID_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .found    (found),
    .winner   (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      en_q      <= '0;
      halted    <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      iram_addr <= '0;
    end else begin
      if (load) begin
        en_q   <= core_en;
        halted <= '0;
      end else if (run) begin
        halted <= halted | (core_halt & en_q);
      end
      s1_valid <= found;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (found) begin
        s1_id     <= win;
        iram_addr <= addr_arr[win];
        if (win == ID_W'(NUM_CORES - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= win + ID_W'(1);
        end
      end
    end
  end

  always_comb begin
    core_gnt    = '0;
    core_rvalid = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_gnt[i]    = s1_valid & (s1_id == ID_W'(i));
      core_rvalid[i] = s2_valid & (s2_id == ID_W'(i));
    end
  end

  assign core_rdata = iram_rdata;
  assign running    = run;
  assign all_done   = (state == DONE);

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Directed bench for iram_fetch_arbiter with a queue of expected
// read returns and a behavioural registered-read IRAM.
module tb_iram_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  core_en;
  logic [3:0]  core_req;
  logic [63:0] core_addr;
  logic [3:0]  core_halt;
  logic [3:0]  core_gnt;
  logic [3:0]  core_rvalid;
  logic [15:0] core_rdata;
  logic [15:0] iram_addr;
  logic [15:0] iram_rdata;
  logic        running;
  logic        all_done;

  logic [15:0] addr [4];
  logic [3:0]  hold_mask;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  oh;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  assign core_addr = {addr[3], addr[2], addr[1], addr[0]};

  function automatic logic [15:0] ram_f(input logic [15:0] a);
    return (a * 16'h0123) ^ 16'hA5C3;
  endfunction

  always @(posedge clk) iram_rdata <= ram_f(iram_addr);

  iram_fetch_arbiter #(
    .NUM_CORES (4),
    .ADDR_W    (16),
    .DATA_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_en     (core_en),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_halt   (core_halt),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .iram_addr   (iram_addr),
    .iram_rdata  (iram_rdata),
    .running     (running),
    .all_done    (all_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] eg);
    exp_t        e;
    logic [3:0]  rv_exp;
    logic [15:0] rd_exp;
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt", 32'(core_gnt), 32'(eg));
    if (eg != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          chk("iram_addr", 32'(iram_addr), 32'(addr[i]));
          e.oh   = eg;
          e.data = ram_f(addr[i]);
          e.due  = cyc + 1;
          q.push_back(e);
        end
      end
      core_req = core_req & ~(eg & ~hold_mask);
    end
    rv_exp = 4'b0;
    rd_exp = 16'h0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e      = q.pop_front();
      rv_exp = e.oh;
      rd_exp = e.data;
    end
    chk("rvalid", 32'(core_rvalid), 32'(rv_exp));
    if (rv_exp != 4'b0) begin
      chk("rdata", 32'(core_rdata), 32'(rd_exp));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    core_en   = 4'b0;
    core_req  = 4'b0;
    core_halt = 4'b0;
    hold_mask = 4'b0;
    for (int i = 0; i < 4; i++) addr[i] = 16'h0;

    step(4'b0000);
    step(4'b0000);
    rst = 1'b0;
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(all_done), 32'd0);
    chk("rst_iram_addr", 32'(iram_addr), 32'd0);

    // single core fetch
    start    = 1'b1;
    core_en  = 4'b0001;
    addr[0]  = 16'd3;
    core_req = 4'b0001;
    step(4'b0000);
    chk("t1_running", 32'(running), 32'd1);
    start = 1'b0;
    step(4'b0001);
    step(4'b0000);
    core_halt = 4'b0001;
    step(4'b0000);
    core_halt = 4'b0000;
    chk("t1_still_run", 32'(running), 32'd1);
    step(4'b0000);
    chk("t1_done", 32'(all_done), 32'd1);
    chk("t1_not_run", 32'(running), 32'd0);

    // all four request at once after a fresh reset
    rst = 1'b1;
    step(4'b0000);
    rst = 1'b0;
    chk("t2_idle_run", 32'(running), 32'd0);
    chk("t2_idle_done", 32'(all_done), 32'd0);
    start   = 1'b1;
    core_en = 4'b1111;
    for (int i = 0; i < 4; i++) addr[i] = 16'(i);
    core_req = 4'b1111;
    step(4'b0000);
    start = 1'b0;
    chk("t2_running", 32'(running), 32'd1);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0000);

    // rr_ptr back at 0: core1 must beat core3
    addr[1]  = 16'h0040;
    addr[3]  = 16'h0077;
    core_req = 4'b1010;
    step(4'b0010);
    step(4'b1000);
    step(4'b0000);

    // core2 holds req through its grant
    addr[2]   = 16'h1234;
    hold_mask = 4'b0100;
    core_req  = 4'b0100;
    step(4'b0100);
    step(4'b0000);
    step(4'b0100);
    hold_mask = 4'b0000;
    core_req  = 4'b0000;
    step(4'b0000);
    step(4'b0000);

    // cores 0 and 1 request continuously
    addr[0]   = 16'h0100;
    addr[1]   = 16'h0200;
    hold_mask = 4'b0011;
    core_req  = 4'b0011;
    step(4'b0001);
    step(4'b0010);
    step(4'b0001);
    step(4'b0010);
    step(4'b0001);
    step(4'b0010);
    hold_mask = 4'b0000;
    core_req  = 4'b0000;
    step(4'b0000);
    step(4'b0000);

    // halt and request on the same edge: halt wins
    core_req  = 4'b1000;
    core_halt = 4'b1000;
    step(4'b0000);
    core_halt = 4'b0000;
    step(4'b0000);
    core_req = 4'b0000;
    step(4'b0000);

    // halt everyone with core1 in flight
    core_req = 4'b0010;
    step(4'b0010);
    core_halt = 4'b1111;
    step(4'b0000);
    core_halt = 4'b0000;
    chk("t5_run_a", 32'(running), 32'd1);
    step(4'b0000);
    chk("t5_not_done", 32'(all_done), 32'd0);
    chk("t5_run_b", 32'(running), 32'd1);
    step(4'b0000);
    chk("t5_done", 32'(all_done), 32'd1);

    // restart clears halted
    start    = 1'b1;
    core_en  = 4'b1111;
    addr[3]  = 16'h0abc;
    core_req = 4'b1000;
    step(4'b0000);
    start = 1'b0;
    chk("t5_rerun", 32'(running), 32'd1);
    step(4'b1000);
    step(4'b0000);

    // reset the cycle after a grant
    addr[0]   = 16'h0055;
    hold_mask = 4'b0001;
    core_req  = 4'b0001;
    step(4'b0001);
    q.delete();
    rst = 1'b1;
    step(4'b0000);
    chk("t6_run", 32'(running), 32'd0);
    chk("t6_done", 32'(all_done), 32'd0);
    rst = 1'b0;
    step(4'b0000);
    step(4'b0000);
    chk("t6_idle", 32'(running), 32'd0);
    hold_mask = 4'b0000;
    core_req  = 4'b0000;

    // start with nothing enabled goes straight to DONE
    start   = 1'b1;
    core_en = 4'b0000;
    step(4'b0000);
    start = 1'b0;
    chk("t7_done", 32'(all_done), 32'd1);
    chk("t7_run", 32'(running), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
